hazard_stall_controller: RTL and testbench

//  Central sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). Tracks in-flight register writes
//  in a per-register scoreboard, stalls ID on RAW hazards, and freezes fetch after a branch/jump/jr/jal

---
 rtl/hazard_stall_controller.sv | 161 ++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: per-register write scoreboard, RAW stall and
// control-flow fetch freeze for the 5-stage MIPS pipeline.
module hazard_stall_controller #(
  parameter int WB_BYPASS    = 1,
  parameter int CTRL_TIMEOUT = 8,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ID_Valid,
  input  logic [4:0]             ID_Rs,
  input  logic [4:0]             ID_Rt,
  input  logic                   ID_ReadsRs,
  input  logic                   ID_ReadsRt,
  input  logic                   ID_RegWrite,
  input  logic [4:0]             ID_WriteRegister,
  input  logic                   ID_IsControl,
  input  logic                   WB_Valid,
  input  logic                   WB_RegWrite,
  input  logic [4:0]             WB_WriteRegister,
  input  logic                   WB_IsControl,
  output logic                   PCWrite,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Bubble,
  output logic [1:0]             State,
  output logic                   HazardError,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam int WAIT_W = $clog2(CTRL_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DATA = 2'd1,
    S_CTRL = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [1:0]             cnt_q [32];
  logic [1:0]             cnt_d [32];
  logic                   herr_q, herr_d;
  logic [STALL_CNT_W-1:0] sc_q, sc_d;

  logic wb_dec, id_inc, issue, hazard;
  logic pend_rs, pend_rt, sb_err, to_err;

  assign wb_dec = WB_Valid & WB_RegWrite &
                  (WB_WriteRegister != 5'd0);

  // A single pending write that WB retires this cycle is visible to
  // ID through the write-first register file.
  always_comb begin
    pend_rs = (ID_Rs != 5'd0) && (cnt_q[ID_Rs] != 2'd0);
    pend_rt = (ID_Rt != 5'd0) && (cnt_q[ID_Rt] != 2'd0);
    if (WB_BYPASS != 0 && wb_dec) begin
      if (cnt_q[ID_Rs] == 2'd1 && WB_WriteRegister == ID_Rs)
        pend_rs = 1'b0;
      if (cnt_q[ID_Rt] == 2'd1 && WB_WriteRegister == ID_Rt)
        pend_rt = 1'b0;
    end
  end

  assign hazard = ID_Valid & ((ID_ReadsRs & pend_rs) |
                              (ID_ReadsRt & pend_rt));
  assign issue  = (state_q != S_CTRL) & ID_Valid & ~hazard;
  assign id_inc = issue & ID_RegWrite &
                  (ID_WriteRegister != 5'd0);

  always_comb begin
    sb_err   = 1'b0;
    cnt_d[0] = 2'd0;
    for (int r = 1; r < 32; r++) begin
      logic inc_r, dec_r;
      inc_r    = id_inc && (ID_WriteRegister == 5'(r));
      dec_r    = wb_dec && (WB_WriteRegister == 5'(r));
      cnt_d[r] = cnt_q[r];
      if (inc_r && !dec_r) begin
        if (cnt_q[r] == 2'd3) sb_err = 1'b1;
        else cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (dec_r && !inc_r) begin
        if (cnt_q[r] == 2'd0) sb_err = 1'b1;
        else cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    to_err       = 1'b0;
    unique case (state_q)
      S_RUN, S_DATA: begin
        unique case (1'b1)
          hazard: begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            state_d      = S_DATA;
          end
          (issue & ID_IsControl): begin
            PCWrite     = 1'b0;
            IF_ID_Flush = 1'b1;
            state_d     = S_CTRL;
            wait_d      = '0;
          end
          default: state_d = S_RUN;
        endcase
      end
      S_CTRL: begin
        PCWrite      = 1'b0;
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
        wait_d       = wait_q + 1'b1;
        if (WB_Valid & WB_IsControl) begin
          PCWrite = 1'b1;
          state_d = S_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(CTRL_TIMEOUT - 1)) begin
          to_err  = 1'b1;
          PCWrite = 1'b1;
          state_d = S_RUN;
          wait_d  = '0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    herr_d = herr_q | sb_err | to_err;
    sc_d   = sc_q;
    if (!PCWrite && sc_q != '1) sc_d = sc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      herr_q  <= 1'b0;
      sc_q    <= '0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      herr_q  <= herr_d;
      sc_q    <= sc_d;
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign State       = state_q;
  assign HazardError = herr_q;
  assign StallCount  = sc_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed vector bench for hazard_stall_controller, with a
// write-first and a non-bypass instance sharing the same stimulus.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       ID_Valid, ID_ReadsRs, ID_ReadsRt;
  logic       ID_RegWrite, ID_IsControl;
  logic [4:0] ID_Rs, ID_Rt, ID_WriteRegister;
  logic       WB_Valid, WB_RegWrite, WB_IsControl;
  logic [4:0] WB_WriteRegister;

  logic        pcw_a, ifw_a, fl_a, bub_a, he_a;
  logic [1:0]  st_a;
  logic [15:0] sc_a;
  logic        pcw_b, ifw_b, fl_b, bub_b, he_b;
  logic [1:0]  st_b;
  logic [15:0] sc_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.WB_BYPASS(1)) dut_a (
    .clk(clk), .reset(reset),
    .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_ReadsRs(ID_ReadsRs), .ID_ReadsRt(ID_ReadsRt),
    .ID_RegWrite(ID_RegWrite),
    .ID_WriteRegister(ID_WriteRegister),
    .ID_IsControl(ID_IsControl),
    .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite),
    .WB_WriteRegister(WB_WriteRegister),
    .WB_IsControl(WB_IsControl),
    .PCWrite(pcw_a), .IF_ID_Write(ifw_a),
    .IF_ID_Flush(fl_a), .ID_EX_Bubble(bub_a),
    .State(st_a), .HazardError(he_a), .StallCount(sc_a)
  );

  hazard_stall_controller #(.WB_BYPASS(0)) dut_b (
    .clk(clk), .reset(reset),
    .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_ReadsRs(ID_ReadsRs), .ID_ReadsRt(ID_ReadsRt),
    .ID_RegWrite(ID_RegWrite),
    .ID_WriteRegister(ID_WriteRegister),
    .ID_IsControl(ID_IsControl),
    .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite),
    .WB_WriteRegister(WB_WriteRegister),
    .WB_IsControl(WB_IsControl),
    .PCWrite(pcw_b), .IF_ID_Write(ifw_b),
    .IF_ID_Flush(fl_b), .ID_EX_Bubble(bub_b),
    .State(st_b), .HazardError(he_b), .StallCount(sc_b)
  );

  typedef struct {
    logic        idv;
    logic [4:0]  rs, rt;
    logic        rrs, rrt, idrw;
    logic [4:0]  idwr;
    logic        idc, wbv, wbrw;
    logic [4:0]  wbwr;
    logic        wbc;
    logic        pcw, ifw, fl, bub;
    logic [1:0]  st;
    logic        he;
    logic [15:0] sc;
    logic        pcwb;
    logic [15:0] scb;
  } vec_t;

  function automatic vec_t mk(
    input logic idv, input logic [4:0] rs, input logic [4:0] rt,
    input logic rrs, input logic rrt, input logic idrw,
    input logic [4:0] idwr, input logic idc,
    input logic wbv, input logic wbrw, input logic [4:0] wbwr,
    input logic wbc,
    input logic pcw, input logic ifw, input logic fl,
    input logic bub, input logic [1:0] st, input logic he,
    input logic [15:0] sc, input logic pcwb,
    input logic [15:0] scb);
    vec_t v;
    v.idv = idv; v.rs = rs; v.rt = rt; v.rrs = rrs;
    v.rrt = rrt; v.idrw = idrw; v.idwr = idwr; v.idc = idc;
    v.wbv = wbv; v.wbrw = wbrw; v.wbwr = wbwr; v.wbc = wbc;
    v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.bub = bub;
    v.st = st; v.he = he; v.sc = sc; v.pcwb = pcwb;
    v.scb = scb;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d want %0d",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ID_Valid         = v.idv;
    ID_Rs            = v.rs;
    ID_Rt            = v.rt;
    ID_ReadsRs       = v.rrs;
    ID_ReadsRt       = v.rrt;
    ID_RegWrite      = v.idrw;
    ID_WriteRegister = v.idwr;
    ID_IsControl     = v.idc;
    WB_Valid         = v.wbv;
    WB_RegWrite      = v.wbrw;
    WB_WriteRegister = v.wbwr;
    WB_IsControl     = v.wbc;
  endtask

  vec_t tbl [28];
  vec_t idle;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0, 0,0,0,0, 1,1,0,0,0,0,0,1,0);
    // $0 traffic never tracked
    tbl[0]  = mk(1,0,0,1,1,1,0,0, 0,0,0,0, 1,1,0,0,0,0,0,1,0);
    tbl[1]  = mk(1,0,0,1,1,1,0,0, 0,0,0,0, 1,1,0,0,0,0,0,1,0);
    // add $8 then consumer of $8
    tbl[2]  = mk(1,1,2,1,1,1,8,0, 0,0,0,0, 1,1,0,0,0,0,0,1,0);
    tbl[3]  = mk(1,8,0,1,0,0,0,0, 0,0,0,0, 0,0,0,1,0,0,0,0,0);
    tbl[4]  = mk(1,8,0,1,0,0,0,0, 0,0,0,0, 0,0,0,1,1,0,1,0,1);
    tbl[5]  = mk(1,8,0,1,0,0,0,0, 1,1,8,0, 1,1,0,0,1,0,2,0,2);
    tbl[6]  = mk(1,8,0,1,0,0,0,0, 0,0,0,0, 1,1,0,0,0,0,2,1,3);
    // $9 inc and dec in the same cycle
    tbl[7]  = mk(1,0,0,0,0,1,9,0, 0,0,0,0, 1,1,0,0,0,0,2,1,3);
    tbl[8]  = mk(1,0,0,0,0,1,9,0, 1,1,9,0, 1,1,0,0,0,0,2,1,3);
    tbl[9]  = mk(1,9,0,1,0,0,0,0, 0,0,0,0, 0,0,0,1,0,0,2,0,3);
    tbl[10] = mk(1,9,0,1,0,0,0,0, 1,1,9,0, 1,1,0,0,1,0,3,0,4);
    tbl[11] = mk(0,0,0,0,0,0,0,0, 0,0,0,0, 1,1,0,0,0,0,3,1,5);
    // beq committed in WB three cycles later
    tbl[12] = mk(1,1,2,1,1,0,0,1, 0,0,0,0, 0,1,1,0,0,0,3,0,5);
    tbl[13] = mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,1,1,1,2,0,4,0,6);
    tbl[14] = mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,1,1,1,2,0,5,0,7);
    tbl[15] = mk(0,0,0,0,0,0,0,0, 1,0,0,1, 1,1,1,1,2,0,6,1,8);
    tbl[16] = mk(0,0,0,0,0,0,0,0, 0,0,0,0, 1,1,0,0,0,0,6,1,8);
    // jr with no commit: timeout
    tbl[17] = mk(1,31,0,1,0,0,0,1, 0,0,0,0, 0,1,1,0,0,0,6,0,8);
    for (int k = 0; k < 7; k++)
      tbl[18+k] = mk(0,0,0,0,0,0,0,0, 0,0,0,0,
                     0,1,1,1,2,0,16'(7+k),0,16'(9+k));
    tbl[25] = mk(0,0,0,0,0,0,0,0, 0,0,0,0, 1,1,1,1,2,0,14,1,16);
    tbl[26] = mk(0,0,0,0,0,0,0,0, 0,0,0,0, 1,1,0,0,0,1,14,1,16);
    tbl[27] = mk(1,3,4,1,1,0,0,0, 0,0,0,0, 1,1,0,0,0,1,14,1,16);

    reset = 1'b0;
    drive(idle);
    #12;
    chk("rst_state", -1, 16'(st_a), 16'd0);
    chk("rst_pcw", -1, 16'(pcw_a), 16'd1);
    chk("rst_ifw", -1, 16'(ifw_a), 16'd1);
    chk("rst_flush", -1, 16'(fl_a), 16'd0);
    chk("rst_bubble", -1, 16'(bub_a), 16'd0);
    chk("rst_herr", -1, 16'(he_a), 16'd0);
    chk("rst_stallcnt", -1, sc_a, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk("pcwrite", i, 16'(pcw_a), 16'(tbl[i].pcw));
      chk("if_id_write", i, 16'(ifw_a), 16'(tbl[i].ifw));
      chk("flush", i, 16'(fl_a), 16'(tbl[i].fl));
      chk("bubble", i, 16'(bub_a), 16'(tbl[i].bub));
      chk("state", i, 16'(st_a), 16'(tbl[i].st));
      chk("herr", i, 16'(he_a), 16'(tbl[i].he));
      chk("stallcnt", i, sc_a, tbl[i].sc);
      chk("pcwrite_nobyp", i, 16'(pcw_b), 16'(tbl[i].pcwb));
      chk("stallcnt_nobyp", i, sc_b, tbl[i].scb);
    end

    // two writes to $8 pending, beq, then reset inside CTRL_WAIT
    @(negedge clk);
    drive(mk(1,0,0,0,0,1,8,0, 0,0,0,0, 1,1,0,0,0,0,0,1,0));
    @(negedge clk);
    drive(mk(1,0,0,0,0,1,8,0, 0,0,0,0, 1,1,0,0,0,0,0,1,0));
    @(negedge clk);
    drive(mk(1,1,0,1,0,0,0,1, 0,0,0,0, 1,1,0,0,0,0,0,1,0));
    @(negedge clk);
    drive(idle);
    #1;
    chk("pre_rst_state", 100, 16'(st_a), 16'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_state", 101, 16'(st_a), 16'd0);
    chk("mid_rst_pcw", 101, 16'(pcw_a), 16'd1);
    chk("mid_rst_herr", 101, 16'(he_a), 16'd0);
    chk("mid_rst_stallcnt", 101, sc_a, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(mk(1,8,8,1,1,0,0,0, 0,0,0,0, 1,1,0,0,0,0,0,1,0));
    #1;
    chk("post_rst_pcw", 102, 16'(pcw_a), 16'd1);
    chk("post_rst_bubble", 102, 16'(bub_a), 16'd0);
    chk("post_rst_pcw_nobyp", 102, 16'(pcw_b), 16'd1);
    @(negedge clk);
    drive(idle);
    #1;
    chk("post_rst_state", 103, 16'(st_a), 16'd0);
    chk("post_rst_stallcnt", 103, sc_a, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
